// File: rtl/fpu_sp_result_buffer.sv
// ============================================================================
// fpu_sp_result_buffer
// ----------------------------------------------------------------------------
// Purpose:
//   Result buffer that sits after the single-precision multiplier. Each
//   product word, together with its overflow/underflow pair, is captured into
//   a small FIFO with valid/ready handshakes on both sides. A downstream
//   consumer (writeback or bus) can therefore stall without losing results.
//   The block also keeps two sticky exception flags that software reads and
//   clears.
//
// Parameters:
//   WIDTH  result word width (32 for single precision)
//   DEPTH  number of FIFO entries, power of two, >= 2
//   AW     pointer width, derived from DEPTH (do not override)
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   in_valid        multiplier result valid this cycle
//   in_ready        buffer can accept a word (not full)
//   in_result       multiplier result word
//   in_overflow     multiplier overflow indication
//   in_underflow    multiplier underflow indication
//   out_valid       head entry available (not empty)
//   out_ready       consumer takes the head entry
//   out_result      head result word, 0 when empty
//   out_overflow    head overflow bit, 0 when empty
//   out_underflow   head underflow bit, 0 when empty
//   count           number of entries held, 0..DEPTH
//   flag_overflow   sticky: some accepted entry had overflow
//   flag_underflow  sticky: some accepted entry had underflow
//   flag_clr        clears both sticky flags
//
// Build option:
//   FPU_SP_SATURATE_EN  when defined, an overflowing result is stored as the
//                       largest finite value with the sign preserved instead
//                       of the incoming infinity. The stored overflow bit and
//                       the sticky overflow flag are not affected.
// ============================================================================
module fpu_sp_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic [AW:0]      count,
    output logic             flag_overflow,
    output logic             flag_underflow,
    input  logic             flag_clr
);

    // Entry layout: {overflow, underflow, result}
    localparam int EW = WIDTH + 2;

    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             flag_ovf_q;
    logic             flag_ovf_d;
    logic             flag_unf_q;
    logic             flag_unf_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] res_store_s;
    logic [EW-1:0]    wr_data_s;
    logic [EW-1:0]    head_s;

    // Full/empty come from the registered count only, so in_ready never
    // sees out_ready combinationally (a full buffer refuses even while
    // the consumer pops in the same cycle).
    always_comb begin
        full_s  = (count_q == CNT_FULL);
        empty_s = (count_q == CNT_ZERO);
        push_s  = in_valid & ~full_s;
        pop_s   = out_ready & ~empty_s;
    end

    // Select the result word that is actually written into storage.
    always_comb begin
        res_store_s = in_result;
`ifdef FPU_SP_SATURATE_EN
        if (in_overflow) begin
            // Largest finite single-precision magnitude, sign kept.
            res_store_s = {in_result[WIDTH-1], 8'hFE, 23'h7FFFFF};
        end else begin
            res_store_s = in_result;
        end
`else
        res_store_s = in_result;
`endif
        wr_data_s = {in_overflow, in_underflow, res_store_s};
    end

    // Next-state logic for pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        flag_ovf_d = flag_ovf_q;
        flag_unf_d = flag_unf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A setting push beats a same-cycle clear.
        flag_ovf_d = (push_s & in_overflow)  | (flag_ovf_q & ~flag_clr);
        flag_unf_d = (push_s & in_underflow) | (flag_unf_q & ~flag_clr);
    end

    // Control registers with synchronous reset; storage is left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= CNT_ZERO;
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flag_ovf_q <= flag_ovf_d;
            flag_unf_q <= flag_unf_d;
        end
    end

    // Storage write port; contents after reset are don't-care because the
    // pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    // Head read straight from storage, forced to zero while empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (empty_s) begin
            out_result    = {WIDTH{1'b0}};
            out_overflow  = 1'b0;
            out_underflow = 1'b0;
        end else begin
            out_result    = head_s[WIDTH-1:0];
            out_overflow  = head_s[EW-1];
            out_underflow = head_s[EW-2];
        end
    end

    // Output port mapping of registered state.
    always_comb begin
        in_ready       = ~full_s;
        out_valid      = ~empty_s;
        count          = count_q;
        flag_overflow  = flag_ovf_q;
        flag_underflow = flag_unf_q;
    end

endmodule

// File: tb/tb_fpu_sp_result_buffer.sv
// ============================================================================
// tb_fpu_sp_result_buffer
// Directed and randomized stimulus for fpu_sp_result_buffer, checked against
// a queue-based reference model of the buffer and its sticky flags.
// ============================================================================
module tb_fpu_sp_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_overflow;
    logic             in_underflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_overflow;
    logic             out_underflow;
    logic [AW:0]      count;
    logic             flag_overflow;
    logic             flag_underflow;
    logic             flag_clr;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of {ovf, unf, result} plus sticky flags.
    logic [WIDTH+1:0] mq[$];
    logic             m_fo;
    logic             m_fu;

    fpu_sp_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_overflow    (in_overflow),
        .in_underflow   (in_underflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_overflow   (out_overflow),
        .out_underflow  (out_underflow),
        .count          (count),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_clr       (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] stored_value(input logic [WIDTH-1:0] d, input logic ov);
`ifdef FPU_SP_SATURATE_EN
        if (ov) return {d[31], 8'hFE, 23'h7FFFFF};
        return d;
`else
        return d;
`endif
    endfunction

    // Compare every DUT output against the model's current view.
    task automatic check_all(input string tag);
        logic [WIDTH+1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check({tag, ".count"},     64'(count),          64'(mq.size()));
        check({tag, ".in_ready"},  64'(in_ready),       64'(mq.size() < DEPTH));
        check({tag, ".out_valid"}, 64'(out_valid),      64'(mq.size() > 0));
        check({tag, ".out_res"},   64'(out_result),     64'(head[WIDTH-1:0]));
        check({tag, ".out_ovf"},   64'(out_overflow),   64'(head[WIDTH+1]));
        check({tag, ".out_unf"},   64'(out_underflow),  64'(head[WIDTH]));
        check({tag, ".flag_ovf"},  64'(flag_overflow),  64'(m_fo));
        check({tag, ".flag_unf"},  64'(flag_underflow), 64'(m_fu));
    endtask

    // One clock cycle: drive, check outputs before the edge, advance model.
    task automatic step(input string tag, input logic v, input logic r, input logic ov,
                        input logic un, input logic [WIDTH-1:0] d, input logic clr,
                        input logic rs);
        bit push;
        bit pop;
        in_valid = v; out_ready = r; in_overflow = ov; in_underflow = un;
        in_result = d; flag_clr = clr; rst = rs;
        #1;
        check_all(tag);
        push = v && (mq.size() < DEPTH);
        pop  = r && (mq.size() > 0);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_fo = 1'b0;
            m_fu = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({ov, un, stored_value(d, ov)});
            m_fo = (push && ov) || (m_fo && !clr);
            m_fu = (push && un) || (m_fu && !clr);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] words [4];
        logic [31:0] sat_exp;
        words[0] = 32'h3F800000; words[1] = 32'h40000000;
        words[2] = 32'h40400000; words[3] = 32'h40800000;

        in_valid = 1'b0; out_ready = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0;
        in_result = 32'h0; flag_clr = 1'b0; rst = 1'b1;
        m_fo = 1'b0; m_fu = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        check_all("reset");

        // Single push then pop with one-cycle latency
        step("p1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40C00000, 1'b0, 1'b0);
        check("tp1_valid", 64'(out_valid), 64'd1);
        check("tp1_res",   64'(out_result), 64'h40C00000);
        step("pop1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("tp1_cnt0",  64'(count), 64'd0);
        check("tp1_res0",  64'(out_result), 64'd0);

        // Fill to full, drop a fifth word, then drain in order
        for (int i = 0; i < 4; i++)
            step("fill", 1'b1, 1'b0, 1'b0, 1'b0, words[i], 1'b0, 1'b0);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_cnt",   64'(count), 64'd4);
        step("drop5", 1'b1, 1'b1, 1'b0, 1'b0, 32'h40A00000, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check("drain_order", 64'(out_result), 64'(words[i]));
            step("drain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        check("drain_cnt0", 64'(count), 64'd0);

        // Wrap-around with steady count of 2
        step("w0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h11110000, 1'b0, 1'b0);
        step("w1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h11110001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 32'h22220000 + 32'(i), 1'b0, 1'b0);
        check("wrap_cnt", 64'(count), 64'd2);
        check("wrap_head", 64'(out_result), 64'h22220008);
        repeat (2) step("wdrain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Sticky overflow survives pop; clear vs set in same cycle
        step("ovf", 1'b1, 1'b0, 1'b1, 1'b0, 32'h7F800000, 1'b0, 1'b0);
        check("flag_ovf_set", 64'(flag_overflow), 64'd1);
        step("ovf_pop", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("flag_ovf_stay", 64'(flag_overflow), 64'd1);
        step("clr_unf", 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0);
        check("clr_ovf0", 64'(flag_overflow), 64'd0);
        check("clr_unf1", 64'(flag_underflow), 64'd1);
        step("unf_pop", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Saturation option
        step("sat", 1'b1, 1'b0, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0);
`ifdef FPU_SP_SATURATE_EN
        sat_exp = 32'hFF7FFFFF;
`else
        sat_exp = 32'hFF800000;
`endif
        check("sat_res", 64'(out_result), 64'(sat_exp));
        check("sat_ovf", 64'(out_overflow), 64'd1);
        step("sat_pop", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset mid-operation with count 3 and flags set
        step("r0", 1'b1, 1'b0, 1'b1, 1'b0, 32'h33330000, 1'b0, 1'b0);
        step("r1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h33330001, 1'b0, 1'b0);
        step("r2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h33330002, 1'b0, 1'b0);
        check("pre_rst_cnt", 64'(count), 64'd3);
        step("rst", 1'b1, 1'b1, 1'b1, 1'b1, 32'h44440000, 1'b0, 1'b1);
        check("rst_cnt",   64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_fo",    64'(flag_overflow), 64'd0);
        check("rst_fu",    64'(flag_underflow), 64'd0);
        idle("post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0),
                 $urandom(),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0));
        end
        idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_sp_result_buffer.md
Name: fpu_sp_result_buffer

Overview:
- Downstream stage of the single-precision multiplier. Captures each product word and its overflow/underflow pair into a small FIFO with valid/ready handshakes, so a consumer (writeback/bus) can stall without losing results.
- Also keeps sticky IEEE-style exception flags that software reads and clears.

Parameters:
- WIDTH, 32, result word width (matches multiplier output).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  multiplier output word is valid this cycle
- in_ready  output  1  buffer can accept (= !full)
- in_result  input  WIDTH  multiplier result
- in_overflow  input  1  multiplier overflow
- in_underflow  input  1  multiplier underflow
- out_valid  output  1  head entry available (= !empty)
- out_ready  input  1  consumer takes head entry
- out_result  output  WIDTH  head result; 0 when empty
- out_overflow  output  1  head overflow bit; 0 when empty
- out_underflow  output  1  head underflow bit; 0 when empty
- count  output  AW+1  entries held, 0..DEPTH
- flag_overflow  output  1  sticky: an accepted entry had overflow
- flag_underflow  output  1  sticky: an accepted entry had underflow
- flag_clr  input  1  clears both sticky flags

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rst.
- On reset: wr_ptr = rd_ptr = 0, count = 0, flags = 0, out_valid = 0, in_ready = 1, out_* = 0. Storage array is not reset.
- Reset mid-operation discards all held entries; the next cycle behaves as after power-up.
- push = in_valid & in_ready. Writes {in_overflow, in_underflow, in_result} at wr_ptr. wr_ptr increments modulo DEPTH (natural wrap, AW bits).
- pop = out_valid & out_ready. rd_ptr increments modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Head read is combinational from storage at rd_ptr, gated to 0 when empty.
- Full (count == DEPTH): in_ready = 0, even if a pop happens the same cycle. in_ready depends only on registered state, with no combinational path from out_ready.
- Empty: out_valid = 0; out_ready is ignored.
- Push and pop in the same cycle with 0 < count < DEPTH: both are performed and count holds.
- in_valid while in_ready = 0: ignored. The upstream holds its data (multiplier inputs held stable).
- Sticky flags: set on the clock after a push whose corresponding bit is 1. flag_clr clears both flags.
- flag_clr in the same cycle as a flag-setting push: the set wins (flag = 1 next cycle).
- Flags are independent of pops and are cleared only by flag_clr or rst.

Optional Feature:
- Macro FPU_SP_SATURATE_EN.
- When defined: on push, if in_overflow = 1, the stored result is {in_result[31], 8'hFE, 23'h7FFFFF} (max finite, sign preserved) instead of the incoming infinity. The stored overflow bit and flag_overflow behave unchanged.
- When undefined: in_result is stored unmodified.

Test Plan:
- Reset, then push 0x40C00000 (3.0*2.0, ovf=0, unf=0) -> next cycle out_valid=1, out_result=0x40C00000, count=1, flags=0. Pop with out_ready=1 -> count=0, out_result=0.
- Push 4 words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is dropped. Drain -> same order, count returns to 0.
- Wrap-around: 10 push/pop pairs at count=2 with in_valid=out_ready=1 -> count stays 2, data order preserved across pointer wrap.
- Push 0x7F800000 with ovf=1 -> flag_overflow=1 and stays 1 after pop. Same-cycle flag_clr plus push with unf=1 -> flag_overflow=0, flag_underflow=1.
- With FPU_SP_SATURATE_EN: push 0xFF800000 with ovf=1 -> out_result=0xFF7FFFFF, out_overflow=1. Without the macro -> out_result=0xFF800000.
- Assert rst with count=3 and flags set -> next cycle count=0, out_valid=0, in_ready=1, flags=0.
